systolic_edge_feeder: RTL and testbench

- Transmit-side driver for the west or north edge of the output-stationary systolic array.
- Accepts one LANES-wide operand vector per systolic pulse over a valid/ready stream.
- Drives per-lane forward/down data and valid with diagonal skew: lane i is delayed by i pulses, so operands meet correctly inside the PE grid.
- Flushes the skew pipeline after the last vector, then signals completion to the layer controller.

---
 rtl/systolic_edge_feeder.sv | 123 ++++++++++++
 tb/tb_systolic_edge_feeder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_edge_feeder.sv
// Edge driver for the systolic array: applies a diagonal skew to operand vectors, then flushes and signals done.
// Optional stat_beats/stat_bubbles counters are compiled in when SYSTOLIC_FEEDER_STATS_EN is defined.
module systolic_edge_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
) (
  input  logic                          core_clk,
  input  logic                          resetn,
  input  logic                          pulse_systolic_module,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_last,
  output logic [LANES-1:0]              feed_valid,
  output logic [LANES*DATA_WIDTH-1:0]   feed_data,
  output logic                          busy,
  output logic                          done
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_bubbles
`endif
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_FLUSH = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] flush_cnt;
  logic          accept;

  assign in_ready = (state == FEED) && pulse_systolic_module;
  assign accept   = in_ready && in_valid;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FEED;
            busy  <= 1'b1;
          end
        end
        FEED: begin
          if (accept && in_last) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (pulse_systolic_module) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == LAST_FLUSH) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Lane i is i+1 stages deep so element i reaches its edge PE i pulses after element 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0]            vld_sr;
    logic [DATA_WIDTH-1:0] dat_sr [i+1];

    always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
        vld_sr <= '0;
        for (int s = 0; s <= i; s++) begin
          dat_sr[s] <= '0;
        end
      end else if (pulse_systolic_module) begin
        vld_sr[0] <= accept;
        dat_sr[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          vld_sr[s] <= vld_sr[s-1];
          dat_sr[s] <= dat_sr[s-1];
        end
      end
    end

    assign feed_valid[i]                          = vld_sr[i];
    assign feed_data[i*DATA_WIDTH +: DATA_WIDTH]  = dat_sr[i];
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      stat_beats   <= '0;
      stat_bubbles <= '0;
    end else if (state == IDLE && start) begin
      stat_beats   <= '0;
      stat_bubbles <= '0;
    end else begin
      if (accept && stat_beats != '1) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (state == FEED && pulse_systolic_module && !in_valid && stat_bubbles != '1) begin
        stat_bubbles <= stat_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench for systolic_edge_feeder: random passes against a pulse-indexed skew model, plus a LANES=1 instance.
module tb_systolic_edge_feeder;

  localparam int DW = 32;
  localparam int LN = 4;

  logic             core_clk;
  logic             resetn;
  logic             pulse;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [LN*DW-1:0] in_data;
  logic             in_last;
  logic [LN-1:0]    feed_valid;
  logic [LN*DW-1:0] feed_data;
  logic             busy;
  logic             done;

  logic             p1, s1, v1, r1, l1, b1, dn1;
  logic [DW-1:0]    d1, fd1;
  logic [0:0]       fv1;

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0] stat_beats, stat_bubbles, sb1, sbb1;
`endif

  systolic_edge_feeder #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .core_clk(core_clk), .resetn(resetn), .pulse_systolic_module(pulse),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .feed_valid(feed_valid), .feed_data(feed_data),
    .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .stat_beats(stat_beats), .stat_bubbles(stat_bubbles)
`endif
  );

  systolic_edge_feeder #(.DATA_WIDTH(DW), .LANES(1)) dut1 (
    .core_clk(core_clk), .resetn(resetn), .pulse_systolic_module(p1),
    .start(s1), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_last(l1), .feed_valid(fv1), .feed_data(fd1),
    .busy(b1), .done(dn1)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .stat_beats(sb1), .stat_bubbles(sbb1)
`endif
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a vector accepted on pulse n is owed to lane i right after pulse n+i.
  typedef struct {
    int            p;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          lq [LN][$];
  int            phase      = 0;   // 0 idle, 1 feed, 2 flush, 3 done
  int            flush_left = 0;
  int            pcnt       = 0;
  int            last_acc   = 0;
  int            m_beats    = 0;
  int            m_bub      = 0;
  logic          last_pulse = 1'b0;
  logic          cur_v [LN];
  logic [DW-1:0] cur_d [LN];

  // Predictor: observes the inputs presented to each clock edge.
  initial forever begin
    @(posedge core_clk);
    if (!resetn) begin
      phase      = 0;
      last_pulse = 1'b0;
      for (int i = 0; i < LN; i++) lq[i].delete();
    end else begin
      last_pulse = pulse;
      if (pulse) pcnt++;
      case (phase)
        0: if (start) begin
          phase   = 1;
          m_beats = 0;
          m_bub   = 0;
        end
        1: if (pulse) begin
          if (in_valid) begin
            for (int i = 0; i < LN; i++) begin
              exp_t e;
              e.p = pcnt + i;
              e.d = in_data[i*DW +: DW];
              lq[i].push_back(e);
            end
            m_beats++;
            last_acc = pcnt;
            if (in_last) begin
              phase      = 2;
              flush_left = LN;
            end
          end else begin
            m_bub++;
          end
        end
        2: if (pulse) begin
          flush_left--;
          if (flush_left == 0) phase = 3;
        end
        default: phase = 0;
      endcase
    end
  end

  // Monitor: compares DUT outputs against the model between edges.
  initial forever begin
    @(negedge core_clk);
    if (!resetn) begin
      chk("reset_outs", {feed_valid, feed_data, busy, done, in_ready}, '0);
      for (int i = 0; i < LN; i++) begin
        cur_v[i] = 1'b0;
        cur_d[i] = '0;
      end
    end else begin
      chk("busy", busy, (phase == 1 || phase == 2));
      chk("done", done, (phase == 3));
      chk("in_ready", in_ready, pulse && phase == 1);
      if (phase == 3) begin
        chk("done_latency", pcnt - last_acc, LN);
        chk("valid_at_done", feed_valid, '0);
      end
      for (int i = 0; i < LN; i++) begin
        if (last_pulse) begin
          cur_v[i] = 1'b0;
          cur_d[i] = '0;
          if (lq[i].size() > 0 && lq[i][0].p == pcnt) begin
            exp_t e;
            e = lq[i].pop_front();
            cur_v[i] = 1'b1;
            cur_d[i] = e.d;
          end
        end
        chk($sformatf("lane%0d", i), {feed_valid[i], feed_data[i*DW +: DW]}, {cur_v[i], cur_d[i]});
      end
    end
  end

  int cc = 0;

  task automatic cyc(input logic p, input logic s, input logic v,
                     input logic [LN*DW-1:0] d, input logic l, output logic acc);
    pulse    = p;
    start    = s;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    #1;
    acc = p && v && in_ready;
    @(posedge core_clk);
    #1;
    cc++;
  endtask

  function automatic logic [LN*DW-1:0] mkvec(input int mode, input int k);
    logic [LN*DW-1:0] v;
    for (int i = 0; i < LN; i++) begin
      case (mode)
        0:       v[i*DW +: DW] = DW'(i + 10 * k);
        1:       v[i*DW +: DW] = DW'(i + 1 + 4 * k);
        default: v[i*DW +: DW] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic run_pass(input int nvec, input int per, input int mode,
                          input int bub_k, input int bub_pct, input bit rnd_start);
    logic acc, p, v, s, bubbled;
    int   k, guard;
    // start cycle also presents a valid vector; it must not be taken
    cyc((cc % per) == 0, 1'b1, 1'b1, mkvec(2, 0), 1'b0, acc);
    k = 0; guard = 0; bubbled = 1'b0;
    while (k < nvec && guard < 2000) begin
      p = (cc % per) == 0;
      v = 1'b1;
      if (p && k == bub_k && !bubbled) begin
        v = 1'b0;
        bubbled = 1'b1;
      end else if ($urandom_range(99) < bub_pct) begin
        v = 1'b0;
      end
      s = rnd_start ? 1'($urandom_range(1)) : 1'b0;
      cyc(p, s, v, mkvec(mode, k), k == nvec - 1, acc);
      if (acc) k++;
      guard++;
    end
    chk("all_vectors_accepted", k, nvec);
    guard = 0;
    while (!done && guard < 200) begin
      s = rnd_start ? 1'($urandom_range(1)) : 1'b0;
      cyc((cc % per) == 0, s, 1'b0, '0, 1'b0, acc);
      guard++;
    end
    chk("done_seen", done, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    chk("idle_after_done", {busy, done}, 2'b00);
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("stat_beats", stat_beats, m_beats);
    chk("stat_bubbles", stat_bubbles, m_bub);
`endif
  endtask

  initial begin
    logic acc;
    int   k;
    resetn = 1'b0; pulse = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    p1 = 1'b0; s1 = 1'b0; v1 = 1'b0; d1 = '0; l1 = 1'b0;
    for (int i = 0; i < LN; i++) begin
      cur_v[i] = 1'b0;
      cur_d[i] = '0;
    end
    #2;
    chk("reset_state", {feed_valid, feed_data, busy, done, in_ready}, '0);
    repeat (2) @(posedge core_clk);
    #1;
    resetn = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, mkvec(2, 0), 1'b0, acc);

    run_pass(3, 1, 0, -1, 0, 1'b0);   // skew: elements i+10k
    run_pass(2, 3, 1, -1, 0, 1'b0);   // sparse pulses
    run_pass(2, 1, 2, 1, 0, 1'b0);    // single bubble between vectors
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("bubble_count_one", stat_bubbles, 32'd1);
`endif
    run_pass(3, 1, 2, -1, 0, 1'b1);   // start toggled while busy
    run_pass(1, 1, 2, -1, 0, 1'b0);   // last on first beat
    run_pass(1, 2, 2, -1, 0, 1'b1);

    // asynchronous reset after two accepts
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, acc);
    k = 0;
    while (k < 2) begin
      cyc(1'b1, 1'b0, 1'b1, mkvec(2, k), 1'b0, acc);
      if (acc) k++;
    end
    pulse = 1'b1; in_valid = 1'b1; in_data = mkvec(2, 5);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_outs", {feed_valid, feed_data, busy, done, in_ready}, '0);
    @(posedge core_clk);
    #1;
    resetn = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
    run_pass(3, 1, 0, -1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_pass($urandom_range(1, 6), $urandom_range(1, 4), 2, -1, 25, 1'b1);
    end
    pulse = 1'b0;

    // LANES=1 instance
    s1 = 1'b1;
    @(posedge core_clk); #1;
    s1 = 1'b0; p1 = 1'b1; v1 = 1'b1; d1 = 32'hDEADBEEF; l1 = 1'b1;
    @(posedge core_clk); #1;
    chk("l1_data", {fv1, fd1, b1, dn1}, {1'b1, 32'hDEADBEEF, 1'b1, 1'b0});
    p1 = 1'b0; v1 = 1'b0; d1 = '0; l1 = 1'b0;
    @(posedge core_clk); #1;
    chk("l1_hold", {fv1, fd1, dn1}, {1'b1, 32'hDEADBEEF, 1'b0});
    p1 = 1'b1;
    @(posedge core_clk); #1;
    chk("l1_done", {fv1, fd1, b1, dn1}, {1'b0, 32'h0, 1'b0, 1'b1});
    p1 = 1'b0;
    @(posedge core_clk); #1;
    chk("l1_done_pulse", {b1, dn1}, 2'b00);

    k = 0;
    for (int i = 0; i < LN; i++) k += lq[i].size();
    chk("scoreboard_drained", k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
